// File: rtl/in_arb_pkg.sv
// Shared types and sizing helpers for the byte-stream IN arbiter.
// Counter widths are derived from the largest value each counter must hold.
package in_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_W_DEFAULT  = cnt_width(8);
  localparam int STALL_W_DEFAULT = cnt_width(16);

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority search: first set request at or above ptr_i,
// wrapping modulo N_REQ.
module rr_picker
  import in_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  // Candidate gi is the requester gi positions above the pointer.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W + 1)'(N_REQ))
                        ? IDX_W'(sum - (IDX_W + 1)'(N_REQ))
                        : IDX_W'(sum);
    assign cand_req[gi] = req_i[cand_idx[gi]];
  end

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        found_o = 1'b1;
        idx_o   = cand_idx[k];
      end
    end
    onehot_o = found_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/in_stream_arbiter.sv
// Round-robin arbiter merging N byte streams into one IN stream, with burst
// limit, stall timeout and a one-entry output register.
module in_stream_arbiter
  import in_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_REQ-1:0]   grant_o
);

  localparam int IDX_W   = idx_width(N_REQ);
  localparam int BEAT_W  = cnt_width(MAX_BURST);
  localparam int STALL_W = cnt_width(IDLE_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;

  logic [7:0]       req_byte [N_REQ];
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             slot_free;
  logic             owner_valid;
  logic             accept;
  logic             end_grant;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_data_i[8*gi +: 8];
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  // The output slot can take a byte when empty or being drained this cycle.
  assign slot_free   = ~out_valid_q | in_ready_i;
  assign owner_valid = req_valid_i[owner_q];
  assign accept      = (state_q == ST_GRANT) & owner_valid & slot_free;

  assign req_ready_o = grant_q & {N_REQ{slot_free}};
  assign grant_o     = grant_q;
  assign in_valid_o  = out_valid_q;
  assign in_data_o   = out_data_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    out_valid_d = out_valid_q & ~in_ready_i;
    out_data_d  = out_data_q;
    end_grant   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          grant_d = pick_onehot;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = req_byte[owner_q];
          beat_d      = beat_q + BEAT_W'(1);
          stall_d     = '0;
          end_grant   = req_last_i[owner_q] | (beat_q == BEAT_W'(MAX_BURST - 1));
        end else if (!owner_valid) begin
          stall_d   = stall_q + STALL_W'(1);
          end_grant = (stall_q == STALL_W'(IDLE_TIMEOUT - 1));
        end
        // Last, burst limit and timeout all funnel into a single release.
        if (end_grant) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          beat_d  = '0;
          stall_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      stall_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_in_stream_arbiter.sv
// Self-checking bench for in_stream_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level round-robin model.
module tb_in_stream_arbiter;

  localparam int N   = 4;
  localparam int MB  = 8;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [7:0]    in_data;
  logic          in_valid, in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // requester sources: data = base + count, last every len bytes (0 = never)
  bit         src_on   [N];
  int         src_cnt  [N];
  int         src_len  [N];
  logic [7:0] src_base [N];

  // reference model state
  bit         m_idle;
  int         m_owner, m_ptr, m_beats, m_stall, m_acc;
  bit         m_vld;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  in_stream_arbiter #(.N_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .grant_o     (grant)
  );

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]      = src_on[k];
      req_data[8*k +: 8] = src_base[k] + 8'(src_cnt[k]);
      req_last[k]       = (src_len[k] != 0) && ((src_cnt[k] % src_len[k]) == src_len[k] - 1);
    end
  endtask

  task automatic model_step();
    bit ended;
    ended = 1'b0;
    m_acc = -1;
    if (rst) begin
      m_idle = 1'b1; m_ptr = 0; m_beats = 0; m_stall = 0; m_vld = 1'b0; m_data = 8'h00;
      return;
    end
    if (m_idle) begin
      if (in_ready) m_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_idle  = 1'b0;
          break;
        end
      end
    end else begin
      if (req_valid[m_owner] && (!m_vld || in_ready)) begin
        m_acc   = m_owner;
        m_data  = req_data[8*m_owner +: 8];
        m_vld   = 1'b1;
        m_beats = m_beats + 1;
        m_stall = 0;
        ended   = req_last[m_owner] || (m_beats == MB);
      end else begin
        if (in_ready) m_vld = 1'b0;
        if (!req_valid[m_owner]) begin
          m_stall = m_stall + 1;
          ended   = (m_stall == TO);
        end
      end
      if (ended) begin
        m_idle = 1'b1; m_ptr = (m_owner + 1) % N; m_beats = 0; m_stall = 0;
      end
    end
  endtask

  // One clock: predict, clock the DUT, let sources see accepted bytes.
  task automatic tick();
    drive();
    model_step();
    @(posedge clk);
    #1;
    if (m_acc >= 0) src_cnt[m_acc] = src_cnt[m_acc] + 1;
    drive();
    #1;
  endtask

  function automatic logic [16:0] exp_vec();
    logic [N-1:0] g;
    g = '0;
    if (!m_idle) g[m_owner] = 1'b1;
    return {g, g & {N{(!m_vld) || in_ready}}, m_vld, m_data};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {grant, req_ready, in_valid, in_data};
  endfunction

  task automatic reset_all();
    for (int k = 0; k < N; k++) begin
      src_on[k] = 1'b0; src_cnt[k] = 0; src_len[k] = 0; src_base[k] = 8'(k * 16);
    end
    in_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    rst = 1'b1;
    src_on[0] = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", in_valid); end
    n_checks++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", in_data); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] exp_b;
    reset_all();
    src_base[0] = 8'hA1; src_len[0] = 3; src_on[0] = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (src_cnt[0] == 3) src_on[0] = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (cyc == 0) begin
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", grant); end
      end
      if (cyc >= 1 && cyc <= 3) begin
        exp_b = 8'hA1 + 8'(cyc - 1);
        n_checks++;
        if (in_valid !== 1'b1 || in_data !== exp_b) begin
          n_fail++; $display("FAIL single_data cyc %0d got %b/%h want 1/%h", cyc, in_valid, in_data, exp_b);
        end
      end
      if (cyc >= 3) begin
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_idle cyc %0d got %b want 0000", cyc, grant); end
      end
    end
    $display("test_single done");
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic test_round_robin();
    int order[$];
    int beats;
    logic [N-1:0] prev;
    reset_all();
    for (int k = 0; k < N; k++) begin src_on[k] = 1'b1; src_base[k] = 8'(k * 64); end
    beats = 0; prev = '0;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      if ((req_valid & req_ready) != '0) beats++;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rr_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (prev == '0 && grant != '0) order.push_back(onehot_idx(grant));
      if (prev != '0 && grant == '0) begin
        n_checks++;
        if (beats != MB) begin n_fail++; $display("FAIL rr_burst got %0d want %0d", beats, MB); end
        beats = 0;
      end
      prev = grant;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= order.size()) begin
        n_fail++; $display("FAIL rr_order grant %0d missing want %0d", i, i % N);
      end else if (order[i] != i % N) begin
        n_fail++; $display("FAIL rr_order grant %0d got %0d want %0d", i, order[i], i % N);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [7:0] got[$];
    reset_all();
    src_base[1] = 8'h20; src_on[1] = 1'b1;
    held = 8'h00;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_ready = !(cyc >= 4 && cyc <= 8);
      if (cyc == 4) held = in_data;
      if (in_valid && in_ready) got.push_back(in_data);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (cyc >= 4 && cyc <= 8) begin
        n_checks++;
        if (in_valid !== 1'b1 || in_data !== held || req_ready !== 4'b0000) begin
          n_fail++; $display("FAIL bp_hold cyc %0d got %b/%h/%b want 1/%h/0000", cyc, in_valid, in_data, req_ready, held);
        end
      end
    end
    n_checks++;
    if (got.size() < 15) begin n_fail++; $display("FAIL bp_count got %0d want >=15", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 8'h20 + 8'(i)) begin
        n_fail++; $display("FAIL bp_seq byte %0d got %h want %h", i, got[i], 8'h20 + 8'(i));
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    reset_all();
    src_base[2] = 8'h50; src_on[2] = 1'b1;
    src_base[3] = 8'h60; src_on[3] = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL to_grant2 got %b want 0100", grant); end
    tick();
    tick();
    src_on[2] = 1'b0;
    for (int s = 1; s <= TO; s++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL to_model stall %0d got %h want %h", s, obs_vec(), exp_vec());
      end
      if (s == TO - 1) begin
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL to_hold got %b want 0100", grant); end
      end
    end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL to_revoke got %b want 0000", grant); end
    src_on[2] = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL to_next got %b want 1000", grant); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_midburst();
    reset_all();
    src_base[2] = 8'h70; src_len[2] = 2; src_on[2] = 1'b1;
    src_base[3] = 8'h80; src_on[3] = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mr_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL mr_owner got %b want 1000", grant); end
    rst = 1'b1;
    src_base[1] = 8'h90; src_on[1] = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || req_ready !== 4'b0000 || in_valid !== 1'b0 || in_data !== 8'h00) begin
      n_fail++; $display("FAIL mr_clear got %b/%b/%b/%h want 0000/0000/0/00", grant, req_ready, in_valid, in_data);
    end
    rst = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mr_ptr0 got %b want 0010", grant); end
    $display("test_reset_midburst done");
  endtask

  task automatic test_last_at_max();
    int beats;
    bool_loop: begin end
    reset_all();
    src_base[1] = 8'hB0; src_len[1] = MB; src_on[1] = 1'b1;
    src_on[2] = 1'b1; src_on[3] = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL lm_grant got %b want 0010", grant); end
    beats = 0;
    for (int cyc = 0; cyc < 20 && grant == 4'b0010; cyc++) begin
      if ((req_valid & req_ready) != '0) beats++;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL lm_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_checks++; if (beats != MB) begin n_fail++; $display("FAIL lm_beats got %0d want %0d", beats, MB); end
    tick();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL lm_next got %b want 0100", grant); end
    $display("test_last_at_max done");
  endtask

  task automatic test_random();
    int sleep_c [N];
    int bad;
    reset_all();
    bad = 0;
    for (int k = 0; k < N; k++) begin
      src_base[k] = 8'($urandom); src_len[k] = $urandom_range(0, 5); sleep_c[k] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (sleep_c[k] > 0) sleep_c[k]--;
        else if ($urandom_range(0, 39) == 0) sleep_c[k] = $urandom_range(5, 25);
        src_on[k] = (sleep_c[k] == 0) && ($urandom_range(0, 9) < 8);
      end
      in_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      rst = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; bad++;
        if (bad <= 10) $display("FAIL rand_model cyc %0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1; in_ready = 1'b1;
    m_idle = 1'b1; m_owner = 0; m_ptr = 0; m_beats = 0; m_stall = 0; m_vld = 1'b0; m_data = 8'h00; m_acc = -1;
    for (int k = 0; k < N; k++) begin src_on[k] = 1'b0; src_cnt[k] = 0; src_len[k] = 0; src_base[k] = 8'h00; end
    drive();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_midburst();
    test_last_at_max();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
